// File: rtl/serdes_pkg.sv
// Shared definitions for the serdes link: receiver FSM states, frame bit values
// and the default word width used by both serializer and deserializer.
package serdes_pkg;

    localparam int unsigned SERDES_DATA_W = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StData     = 3'd1,
        StParity   = 3'd2,
        StStop     = 3'd3,
        StWaitIdle = 3'd4
    } rx_state_t;

endpackage

// File: rtl/serdes_rx_buf.sv
// One-entry valid/ready output register for the deserializer. A load is taken
// when the slot is empty or is being drained in the same cycle; otherwise it
// is dropped and flagged as an overrun pulse.
module serdes_rx_buf #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_perr,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_perr,
    output logic              o_overrun
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_perr;
    logic              r_overrun;

    logic w_accept;
    logic w_space;
    logic w_take;

    assign w_accept = r_valid & i_ready;
    assign w_space  = ~r_valid | w_accept;
    assign w_take   = i_load & w_space;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_load & ~w_space;
            if (w_take) begin
                r_data  <= i_data;
                r_perr  <= i_perr;
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_perr    = r_perr;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/serdes_deser_rx.sv
// Serial-to-parallel receiver: strips start/parity/stop framing from the bit
// strobe stream and hands words to a one-entry valid/ready buffer.
module serdes_deser_rx
    import serdes_pkg::*;
#(
    parameter int unsigned DATA_W     = SERDES_DATA_W,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_ser_en,
    input  logic              i_ser_in,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_data_valid,
    input  logic              i_data_ready,
    output logic              o_parity_err,
    output logic              o_frame_err,
    output logic              o_overrun,
    output logic              o_busy
);

    localparam int unsigned       CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_t         r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shreg;
    logic              r_pe;
    logic              r_frame_err;

    rx_state_t         w_state_nxt;
    logic [CNT_W-1:0]  w_bit_cnt_nxt;
    logic [DATA_W-1:0] w_shreg_nxt;
    logic              w_pe_nxt;
    logic              w_frame_err_nxt;
    logic              w_frame_good;
    logic              w_perr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_pe        <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shreg     <= w_shreg_nxt;
            r_pe        <= w_pe_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shreg_nxt     = r_shreg;
        w_pe_nxt        = r_pe;
        w_frame_err_nxt = 1'b0;
        w_frame_good    = 1'b0;

        if (i_ser_en) begin
            unique case (r_state)
                StIdle: begin
                    if (i_ser_in == START_BIT) begin
                        w_state_nxt   = StData;
                        w_bit_cnt_nxt = '0;
                        w_pe_nxt      = 1'b0;
                    end
                end
                StData: begin
                    // LSB arrives first, so shifting in at the top leaves it in bit 0.
                    w_shreg_nxt   = {i_ser_in, r_shreg[DATA_W-1:1]};
                    w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt = PARITY_EN ? StParity : StStop;
                    end
                end
                StParity: begin
                    w_pe_nxt    = (^r_shreg) ^ i_ser_in ^ PARITY_ODD;
                    w_state_nxt = StStop;
                end
                StStop: begin
                    if (i_ser_in == STOP_BIT) begin
                        w_frame_good = 1'b1;
                        w_state_nxt  = StIdle;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = StWaitIdle;
                    end
                end
                StWaitIdle: begin
                    // A line stuck low must not be decoded as a stream of start bits.
                    if (i_ser_in == STOP_BIT) begin
                        w_state_nxt = StIdle;
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                end
            endcase
        end
    end

    assign w_perr = PARITY_EN ? r_pe : 1'b0;

    serdes_rx_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_frame_good),
        .i_data    (r_shreg),
        .i_perr    (w_perr),
        .i_ready   (i_data_ready),
        .o_data    (o_data_out),
        .o_valid   (o_data_valid),
        .o_perr    (o_parity_err),
        .o_overrun (o_overrun)
    );

    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state != StIdle);

endmodule
